// File: rtl/flow_fifo_vldrdy.sv
// rtl/flow_fifo_vldrdy.sv - valid/ready FIFO stage between width converters and sink
module flow_fifo_vldrdy #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 4,
  parameter int LWIDTH = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic              src_val,
  output logic              src_rdy,
  input  logic [DWIDTH-1:0] src_data,
  output logic              dst_val,
  input  logic              dst_rdy,
  output logic [DWIDTH-1:0] dst_data,
  output logic [LWIDTH-1:0] level
);

  localparam int PWIDTH = $clog2(DEPTH);
  localparam logic [LWIDTH-1:0] FULL_CNT = LWIDTH'(DEPTH);

  logic [PWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LWIDTH-1:0] count_q, count_d;
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] mem_d [DEPTH];
  logic              wr_en;
  logic              rd_en;

  // Ready/valid come only from registered occupancy and cfg_en, so neither
  // side sees a combinational path from the other.
  assign src_rdy  = cfg_en && (count_q < FULL_CNT);
  assign dst_val  = cfg_en && (count_q != '0);
  assign wr_en    = src_val && src_rdy;
  assign rd_en    = dst_val && dst_rdy;
  assign dst_data = mem_q[rd_ptr_q];
  assign level    = count_q;

  // Next-state: store on write, advance pointers, track occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = src_data;
      wr_ptr_d        = wr_ptr_q + PWIDTH'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PWIDTH'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + LWIDTH'(1);
      2'b01:   count_d = count_q - LWIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; storage is cleared too so dst_data reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  a_count_max: assert property (@(posedge clk) disable iff (rst) count_q <= FULL_CNT);
  a_no_write_full: assert property (@(posedge clk) disable iff (rst) !(wr_en && (count_q == FULL_CNT)));

endmodule

// File: tb/tb_flow_fifo_vldrdy.sv
// tb/tb_flow_fifo_vldrdy.sv - randomized and directed bench for flow_fifo_vldrdy
module tb_flow_fifo_vldrdy;

  localparam int DWIDTH = 16;
  localparam int DEPTH  = 4;
  localparam int LWIDTH = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_en;
  logic              src_val;
  logic              src_rdy;
  logic [DWIDTH-1:0] src_data;
  logic              dst_val;
  logic              dst_rdy;
  logic [DWIDTH-1:0] dst_data;
  logic [LWIDTH-1:0] level;

  int checks = 0;
  int errors = 0;
  bit model_ok = 1'b0;

  logic [DWIDTH-1:0] model_q[$];
  logic [DWIDTH-1:0] got[$];

  flow_fifo_vldrdy #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en),
    .src_val(src_val), .src_rdy(src_rdy), .src_data(src_data),
    .dst_val(dst_val), .dst_rdy(dst_rdy), .dst_data(dst_data),
    .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: an ideal FIFO of capacity DEPTH that moves words when enabled.
  always @(posedge clk) begin
    bit wr, rd;
    if (rst) begin
      model_q.delete();
    end else begin
      wr = cfg_en && src_val && (model_q.size() < DEPTH);
      rd = cfg_en && dst_rdy && (model_q.size() != 0);
      if (rd) void'(model_q.pop_front());
      if (wr) model_q.push_back(src_data);
    end
  end

  // Cycle-by-cycle comparison against the reference.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_src_rdy", src_rdy, cfg_en && (model_q.size() < DEPTH));
      chk("m_dst_val", dst_val, cfg_en && (model_q.size() != 0));
      chk("m_level", level, model_q.size());
      if (model_q.size() != 0) chk("m_dst_data", dst_data, model_q[0]);
    end
  end

  initial begin
    logic [DWIDTH-1:0] words [4];
    words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    rst = 1'b1; cfg_en = 1'b0; src_val = 1'b1; src_data = 16'hDEAD; dst_rdy = 1'b0;

    // Reset and idle
    for (int i = 0; i < 3; i++) begin
      step();
      model_ok = 1'b1;
      chk("rst_src_rdy", src_rdy, 0);
      chk("rst_dst_val", dst_val, 0);
      chk("rst_dst_data", dst_data, 0);
      chk("rst_level", level, 0);
    end
    rst = 1'b0; cfg_en = 1'b1; src_val = 1'b0;
    #1;
    chk("post_rst_src_rdy", src_rdy, 1);

    // Fill then drain
    for (int i = 0; i < 4; i++) begin
      src_val = 1'b1; src_data = words[i];
      step();
      chk("fill_level", level, i + 1);
    end
    src_val = 1'b0;
    chk("full_src_rdy", src_rdy, 0);
    dst_rdy = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_val", dst_val, 1);
      chk("drain_data", dst_data, words[i]);
      step();
    end
    chk("drained_val", dst_val, 0);
    chk("drained_level", level, 0);

    // Full with simultaneous read: no bypass
    dst_rdy = 1'b0; src_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src_data = 16'h5001 + 16'(i);
      step();
    end
    src_data = 16'h5005; dst_rdy = 1'b1;
    #1;
    chk("full_rd_src_rdy", src_rdy, 0);
    step();
    chk("full_rd_level", level, 3);
    chk("full_rd_rdy_back", src_rdy, 1);
    chk("full_rd_head", dst_data, 16'h5002);
    step();
    chk("both_level", level, 3);
    src_val = 1'b0;
    for (int i = 0; i < 10 && level != 0; i++) step();
    chk("full_rd_drained", level, 0);

    // Streaming with pointer wrap
    src_val = 1'b1; dst_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      src_data = 16'(k);
      #1;
      if (dst_val) got.push_back(dst_data);
      step();
      chk("stream_level", level, 1);
    end
    src_val = 1'b0;
    #1;
    if (dst_val) got.push_back(dst_data);
    step();
    chk("stream_end_level", level, 0);
    chk("stream_count", got.size(), 20);
    for (int i = 0; i < got.size(); i++) chk("stream_data", got[i], i);

    // cfg_en drop mid-burst
    dst_rdy = 1'b0; src_val = 1'b1;
    src_data = 16'h00A0; step();
    src_data = 16'h00A1; step();
    chk("en_level", level, 2);
    cfg_en = 1'b0; src_data = 16'h00A2; dst_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("dis_level", level, 2);
      chk("dis_src_rdy", src_rdy, 0);
      chk("dis_dst_val", dst_val, 0);
    end
    cfg_en = 1'b1; src_val = 1'b0;
    #1;
    chk("resume_0", dst_data, 16'h00A0);
    step();
    chk("resume_1", dst_data, 16'h00A1);
    step();
    chk("resume_level", level, 0);

    // Random traffic, back-pressure, disables and occasional reset
    for (int n = 0; n < 4000; n++) begin
      rst      = ($urandom_range(0, 399) == 0);
      cfg_en   = ($urandom_range(0, 9) != 0);
      src_val  = $urandom_range(0, 1) == 1;
      src_data = DWIDTH'($urandom);
      dst_rdy  = ($urandom_range(0, 2) != 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
